// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage plus the IF/ID pipeline register.
// It owns the PC and drives the instruction ROM address. Each edge it latches the
// fetched word and its PC+4 into IF/ID. Stall requests hold the stage. A redirect
// loads a new PC and flushes the wrong-path instruction as a NOP bubble.
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   imem_addr        ROM address (current PC)
//   imem_data        ROM word for imem_addr (combinational)
//   stall            hold PC and IF/ID
//   redirect         load a new PC this edge and insert a bubble
//   redirect_sel     00 branch, 01 j/jal, 10 jr, 11 treated as branch
//   rd_pc_4          PC+4 of the redirecting instruction
//   rd_imm           sign-extended branch immediate
//   rd_addr          j/jal target field
//   rd_rs            rs value for jr
//   ifid_instr       latched instruction
//   ifid_pc_4        latched PC+4 of ifid_instr
//   ifid_valid       1 = real instruction, 0 = bubble
//   fetch_count      instructions loaded valid into IF/ID
module fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] JUMP_OFFSET = 32'd12288,
    parameter logic [31:0] NOP         = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [1:0]  redirect_sel,
    input  logic [31:0] rd_pc_4,
    input  logic [31:0] rd_imm,
    input  logic [25:0] rd_addr,
    input  logic [31:0] rd_rs,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc_4,
    output logic        ifid_valid,
    output logic [31:0] fetch_count
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ifid_pc_4_q, ifid_pc_4_d;
    logic        valid_q, valid_d;
    logic [31:0] count_q, count_d;
    logic [31:0] pc_4;
    logic [31:0] target;

    // The branch immediate is word-scaled, so its top two bits fall off. jr
    // forces word alignment, so the low two rs bits are ignored.
    logic unused_bits;
    assign unused_bits = ^{rd_imm[31:30], rd_rs[1:0]};

    assign pc_4      = pc_q + 32'd4;
    assign imem_addr = pc_q;

    always_comb begin
        target = rd_pc_4 + {rd_imm[29:0], 2'b00};
        unique case (redirect_sel)
            2'b01:   target = {rd_pc_4[31:28], rd_addr, 2'b00} - JUMP_OFFSET;
            2'b10:   target = {rd_rs[31:2], 2'b00};
            default: target = rd_pc_4 + {rd_imm[29:0], 2'b00};
        endcase
    end

    // Priority: redirect > stall > normal fetch.
    always_comb begin
        pc_d        = pc_q;
        instr_d     = instr_q;
        ifid_pc_4_d = ifid_pc_4_q;
        valid_d     = valid_q;
        count_d     = count_q;
        if (redirect) begin
            pc_d        = target;
            instr_d     = NOP;
            ifid_pc_4_d = 32'd0;
            valid_d     = 1'b0;
        end else if (!stall) begin
            pc_d        = pc_4;
            instr_d     = imem_data;
            ifid_pc_4_d = pc_4;
            valid_d     = 1'b1;
            count_d     = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            instr_q     <= NOP;
            ifid_pc_4_q <= 32'd0;
            valid_q     <= 1'b0;
            count_q     <= 32'd0;
        end else begin
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            ifid_pc_4_q <= ifid_pc_4_d;
            valid_q     <= valid_d;
            count_q     <= count_d;
        end
    end

    assign ifid_instr  = instr_q;
    assign ifid_pc_4   = ifid_pc_4_q;
    assign ifid_valid  = valid_q;
    assign fetch_count = count_q;

endmodule
